// File: rtl/mac8_pkg.sv
// mac8_pkg: shared state encoding and sizing constants for the serial 8x8 MAC controller.
package mac8_pkg;
  typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;
  localparam int ACC_W_DEF = 20;
  localparam int N_STEPS = 16;
endpackage

// File: rtl/vedic_2bit_multiplier.sv
// vedic_2bit_multiplier: 2x2 unsigned multiplier built from the vertical/crosswise partial products.
module vedic_2bit_multiplier (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic c1;
  logic hi;
  assign c1 = a[1] & b[0] & a[0] & b[1];
  assign hi = a[1] & b[1];
  assign p = {hi & c1, hi ^ c1, (a[1] & b[0]) ^ (a[0] & b[1]), a[0] & b[0]};
endmodule

// File: rtl/mac8_seq_ctrl.sv
// mac8_seq_ctrl: multiply-accumulate controller that builds an 8x8 product from sixteen
// 2x2 partial products using one shared multiplier, then folds it into a wrapping accumulator.
module mac8_seq_ctrl
  import mac8_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic             acc_clr,
  output logic             out_valid,
  output logic [ACC_W-1:0] acc,
  output logic             ovf,
  output logic             busy
);
  state_t           state_q, state_d;
  logic [7:0]       a_q, a_d, b_q, b_d;
  logic             clr_q, clr_d;
  logic [3:0]       k_q, k_d;
  logic [15:0]      prod_q, prod_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [1:0]       step_i, step_j, mul_a, mul_b;
  logic [3:0]       mul_p, shamt;
  logic [ACC_W:0]   sum;
  assign step_i = k_q[1:0];
  assign step_j = k_q[3:2];
  assign mul_a = a_q[{step_i, 1'b0} +: 2];
  assign mul_b = b_q[{step_j, 1'b0} +: 2];
  assign shamt = {{1'b0, step_i} + {1'b0, step_j}, 1'b0};
  assign sum = {1'b0, acc_q} + (ACC_W+1)'(prod_q);
  vedic_2bit_multiplier u_mul (
    .a(mul_a),
    .b(mul_b),
    .p(mul_p)
  );
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    clr_d = clr_q;
    k_d = k_q;
    prod_d = prod_q;
    acc_d = acc_q;
    ovf_d = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d = a;
          b_d = b;
          clr_d = acc_clr;
          k_d = '0;
          prod_d = '0;
          state_d = MUL;
        end else if (acc_clr) begin
          acc_d = '0;
          ovf_d = 1'b0;
        end
      end
      MUL: begin
        prod_d = prod_q + ({12'b0, mul_p} << shamt);
        k_d = k_q + 4'd1;
        state_d = (k_q == 4'(N_STEPS - 1)) ? ACC : MUL;
      end
      ACC: begin
        // A latched clear discards the old total, so no carry can be produced.
        acc_d = clr_q ? ACC_W'(prod_q) : sum[ACC_W-1:0];
        ovf_d = clr_q ? 1'b0 : (ovf_q | sum[ACC_W]);
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      clr_q <= 1'b0;
      k_q <= '0;
      prod_q <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      clr_q <= clr_d;
      k_q <= k_d;
      prod_q <= prod_d;
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end
  assign in_ready = (state_q == IDLE);
  assign busy = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign acc = acc_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_mac8_seq_ctrl.sv
// tb_mac8_seq_ctrl: directed vector bench for the serial MAC controller, with cycle-exact latency checks.
module tb_mac8_seq_ctrl;
  localparam int ACC_W = 20;
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             acc_clr = 1'b0;
  logic [7:0]       a = '0;
  logic [7:0]       b = '0;
  logic             in_ready, out_valid, ovf, busy;
  logic [ACC_W-1:0] acc;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        clr;
    logic [31:0] acc;
    logic        ovf;
  } vec_t;
  vec_t tv[3];
  mac8_seq_ctrl #(.ACC_W(ACC_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .acc_clr(acc_clr),
    .out_valid(out_valid),
    .acc(acc),
    .ovf(ovf),
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // Called at a negedge while idle; accept happens at the next posedge (cycle 0).
  task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vclr,
                        input logic [31:0] eacc, input logic eovf);
    logic [31:0] prev;
    prev = 32'(acc);
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    a = va;
    b = vb;
    acc_clr = vclr;
    in_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 19; c++) begin
      @(negedge clk);
      if (c == 1) begin
        in_valid = 1'b0;
        acc_clr = 1'b0;
        a = ~va;
        b = vb ^ 8'h5a;
      end
      if (c <= 17) chk("acc_stable_while_busy", 32'(acc), prev);
      chk("out_valid_timing", 32'(out_valid), 32'(c == 18));
      chk("busy_timing", 32'(busy), 32'(c <= 18));
      chk("in_ready_timing", 32'(in_ready), 32'(c == 19));
      if (c == 18) begin
        chk("acc_result", 32'(acc), eacc);
        chk("ovf_result", 32'(ovf), 32'(eovf));
      end
    end
  endtask
  initial begin
    logic [31:0] exp_acc;
    int pulses;
    logic [31:0] prev;
    tv[0] = '{a: 8'd255, b: 8'd255, clr: 1'b1, acc: 32'd65025, ovf: 1'b0};
    tv[1] = '{a: 8'd255, b: 8'd255, clr: 1'b0, acc: 32'd130050, ovf: 1'b0};
    tv[2] = '{a: 8'd3, b: 8'd5, clr: 1'b1, acc: 32'd15, ovf: 1'b0};
    #1;
    chk("reset_acc", 32'(acc), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 3; n++) run_op(tv[n].a, tv[n].b, tv[n].clr, tv[n].acc, tv[n].ovf);
    acc_clr = 1'b1;
    @(negedge clk);
    acc_clr = 1'b0;
    chk("idle_clr_acc", 32'(acc), 32'd0);
    chk("idle_clr_ovf", 32'(ovf), 32'd0);
    chk("idle_clr_no_out_valid", 32'(out_valid), 32'd0);
    chk("idle_clr_not_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("idle_clr_no_out_valid_later", 32'(out_valid), 32'd0);
    exp_acc = 0;
    for (int n = 1; n <= 17; n++) begin
      exp_acc = (n == 1) ? 32'd65025 : (exp_acc + 32'd65025) % 32'd1048576;
      run_op(8'd255, 8'd255, n == 1, exp_acc, n == 17);
    end
    chk("wrap_value", exp_acc, 32'd56849);
    run_op(8'd1, 8'd1, 1'b0, 32'd56850, 1'b1);
    run_op(8'd2, 8'd2, 1'b1, 32'd4, 1'b0);
    prev = 32'(acc);
    pulses = 0;
    a = 8'd1;
    b = 8'd1;
    in_valid = 1'b1;
    for (int c = 1; c <= 38; c++) begin
      @(negedge clk);
      if (out_valid) begin
        pulses++;
        chk("held_pulse_cycle", c, (pulses == 1) ? 32'd18 : 32'd37);
      end
      chk("held_in_ready", 32'(in_ready), 32'(c == 19 || c == 38));
      if (c == 38) in_valid = 1'b0;
    end
    chk("held_pulse_count", pulses, 32'd2);
    chk("held_acc", 32'(acc), prev + 32'd2);
    @(negedge clk);
    chk("held_no_extra_accept", 32'(busy), 32'd0);
    a = 8'd7;
    b = 8'd9;
    in_valid = 1'b1;
    @(posedge clk);
    repeat (8) @(negedge clk);
    in_valid = 1'b0;
    chk("mid_mul_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_acc", 32'(acc), 32'd0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(8'd2, 8'd3, 1'b0, 32'd6, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
